// File: rtl/thor2022_icinv_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : thor2022_icinv_ctrl_if
// Description : Request/response bundle between the core, the bus snooper, the
//               refill path and the I-cache invalidate controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface thor2022_icinv_ctrl_if #(
    parameter int AWID = 32,
    parameter int CNTW = 8
);
    logic            refill_wr;
    logic            core_req;
    logic [1:0]      core_op;
    logic [AWID-1:0] core_adr;
    logic [CNTW-1:0] core_cnt;
    logic            core_ack;
    logic            snp_v;
    logic [AWID-1:0] snp_adr;
    logic            snp_rdy;
    logic            invce;
    logic            invline;
    logic            invall;
    logic [AWID-1:0] adr;
    logic            busy;
    logic            stall_fetch;
    logic [31:0]     inv_count;

    modport slave (
        input  refill_wr, core_req, core_op, core_adr, core_cnt, snp_v, snp_adr,
        output core_ack, snp_rdy, invce, invline, invall, adr, busy, stall_fetch,
               inv_count
    );

    modport master (
        output refill_wr, core_req, core_op, core_adr, core_cnt, snp_v, snp_adr,
        input  core_ack, snp_rdy, invce, invline, invall, adr, busy, stall_fetch,
               inv_count
    );
endinterface
`default_nettype wire

// File: rtl/thor2022_icinv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : thor2022_icinv_ctrl
// Description : Arbitrates core cache-control ops and queued bus-snoop
//               invalidates onto the I-cache valid array's invalidate port.
//               Define ICINV_STATS_EN to enable the invalidate counter.
// Revision    : 1.0 - initial release
// ============================================================================
module thor2022_icinv_ctrl #(
    parameter int AWID      = 32,
    parameter int LINES     = 128,
    parameter int SNP_DEPTH = 4,
    parameter int CNTW      = 8
) (
    input wire clk,
    input wire rst,
    thor2022_icinv_ctrl_if.slave bus
);

    localparam int PW = $clog2(SNP_DEPTH);
    localparam int LW = AWID - 6;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_issue = 2'd1;
    localparam logic [1:0] c_st_range = 2'd2;
    localparam logic [1:0] c_st_ack   = 2'd3;

    localparam logic [1:0] c_op_line  = 2'd0;
    localparam logic [1:0] c_op_all   = 2'd1;
    localparam logic [1:0] c_op_range = 2'd2;

    localparam logic [AWID-1:0] c_line_step = AWID'(64);
    localparam logic [31:0]     c_lines     = 32'(LINES);

    logic [1:0]      r_state;
    logic [AWID-1:0] r_adr;
    logic [CNTW-1:0] r_rem;
    logic            r_all;
    logic            r_core;
    logic            r_gnt_v;
    logic            r_gnt_core;
    logic            r_rr;
    logic            r_ovf;
    logic [PW:0]     r_wp;
    logic [PW:0]     r_rp;
    logic [LW-1:0]   r_mem [SNP_DEPTH];

    logic            w_empty;
    logic            w_full;
    logic            w_pend;
    logic            w_invce;
    logic            w_arb;
    logic            w_pick_core;
    logic            w_act;
    logic            w_act_snp;
    logic            w_flush;
    logic            w_pop;
    logic            w_push;
    logic [LW-1:0]   w_head;
    logic [31:0]     w_cnt32;
    logic            w_unused;

    // ------------------------------------------------------------------------
    // Snoop FIFO: pointers carry one extra wrap bit to tell full from empty.
    // ------------------------------------------------------------------------
    assign w_empty = (r_wp == r_rp);
    assign w_full  = (r_wp[PW] != r_rp[PW]) && (r_wp[PW-1:0] == r_rp[PW-1:0]);
    assign w_head  = r_mem[r_rp[PW-1:0]];

    assign w_pend      = (r_state == c_st_issue) || (r_state == c_st_range);
    assign w_invce     = w_pend & ~bus.refill_wr;
    assign w_arb       = (r_state == c_st_idle) & ~r_gnt_v & (bus.core_req | ~w_empty);
    assign w_pick_core = bus.core_req & (w_empty | r_rr);
    assign w_act       = (r_state == c_st_idle) & r_gnt_v;
    assign w_act_snp   = w_act & ~r_gnt_core;
    // An overflowed queue can no longer be trusted, so its grant flushes it
    // and the resulting invall covers every dropped or queued address.
    assign w_flush     = w_act_snp & r_ovf;
    assign w_pop       = w_act_snp & ~r_ovf;
    assign w_push      = bus.snp_v & ~w_full & ~w_flush;
    assign w_cnt32     = 32'(bus.core_cnt);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wp[PW-1:0]] <= bus.snp_adr[AWID-1:6];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_ovf <= 1'b0;
        end else begin
            if (w_flush) begin
                r_rp <= r_wp;
            end else begin
                if (w_push) r_wp <= r_wp + 1'b1;
                if (w_pop)  r_rp <= r_rp + 1'b1;
            end
            if (w_flush) begin
                r_ovf <= 1'b0;
            end else if (bus.snp_v && w_full) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Sequencer. A grant is chosen in one IDLE cycle and acted on in the next.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_adr      <= '0;
            r_rem      <= '0;
            r_all      <= 1'b0;
            r_core     <= 1'b0;
            r_gnt_v    <= 1'b0;
            r_gnt_core <= 1'b0;
            r_rr       <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_arb) begin
                        r_gnt_v    <= 1'b1;
                        r_gnt_core <= w_pick_core;
                        if (bus.core_req && !w_empty) r_rr <= ~r_rr;
                    end else if (r_gnt_v) begin
                        r_gnt_v <= 1'b0;
                        r_core  <= r_gnt_core;
                        if (!r_gnt_core) begin
                            if (r_ovf) begin
                                r_all <= 1'b1;
                                r_adr <= '0;
                            end else begin
                                r_all <= 1'b0;
                                r_adr <= {w_head, 6'b0};
                            end
                            r_state <= c_st_issue;
                        end else begin
                            case (bus.core_op)
                                c_op_line: begin
                                    r_all   <= 1'b0;
                                    r_adr   <= {bus.core_adr[AWID-1:6], 6'b0};
                                    r_state <= c_st_issue;
                                end
                                c_op_all: begin
                                    r_all   <= 1'b1;
                                    r_adr   <= '0;
                                    r_state <= c_st_issue;
                                end
                                c_op_range: begin
                                    if (bus.core_cnt == '0) begin
                                        r_state <= c_st_ack;
                                    end else if (w_cnt32 >= c_lines) begin
                                        r_all   <= 1'b1;
                                        r_adr   <= '0;
                                        r_state <= c_st_issue;
                                    end else begin
                                        r_all   <= 1'b0;
                                        r_adr   <= {bus.core_adr[AWID-1:6], 6'b0};
                                        r_rem   <= bus.core_cnt;
                                        r_state <= c_st_range;
                                    end
                                end
                                default: begin
                                    r_state <= c_st_ack;
                                end
                            endcase
                        end
                    end
                end
                c_st_issue: begin
                    if (w_invce) begin
                        r_state <= r_core ? c_st_ack : c_st_idle;
                    end
                end
                c_st_range: begin
                    if (w_invce) begin
                        r_adr <= r_adr + c_line_step;
                        r_rem <= r_rem - 1'b1;
                        if (r_rem == CNTW'(1)) begin
                            r_state <= c_st_ack;
                        end
                    end
                end
                c_st_ack: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

`ifdef ICINV_STATS_EN
    logic [31:0] r_inv_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inv_count <= '0;
        end else if (w_invce && (r_inv_count != '1)) begin
            r_inv_count <= r_inv_count + 1'b1;
        end
    end

    assign bus.inv_count = r_inv_count;
`else
    assign bus.inv_count = '0;
`endif

    assign bus.invce       = w_invce;
    assign bus.invline     = w_invce & ~r_all;
    assign bus.invall      = w_invce & r_all;
    assign bus.adr         = r_adr;
    assign bus.core_ack    = (r_state == c_st_ack);
    assign bus.snp_rdy     = ~w_full;
    assign bus.busy        = (r_state != c_st_idle) | r_gnt_v | ~w_empty;
    assign bus.stall_fetch = bus.busy;

    // Sub-line offset bits are never used: invalidates are line granular.
    assign w_unused = &{1'b0, bus.core_adr[5:0], bus.snp_adr[5:0]};

endmodule
`default_nettype wire

// File: tb/tb_thor2022_icinv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_thor2022_icinv_ctrl
// Description : Scoreboard bench for the I-cache invalidate controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_thor2022_icinv_ctrl;

    localparam int AWID = 32;
    localparam int CNTW = 8;

    typedef struct packed {
        logic [31:0] a;
        logic        line;
        logic        all;
    } inv_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    thor2022_icinv_ctrl_if #(.AWID(AWID), .CNTW(CNTW)) bus ();

    thor2022_icinv_ctrl #(
        .AWID      (AWID),
        .LINES     (128),
        .SNP_DEPTH (4),
        .CNTW      (CNTW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    int   ack_cnt  = 0;
    int   inv_seen = 0;
    inv_t exp_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] a, input logic line, input logic all);
        inv_t e;
        e.a    = a;
        e.line = line;
        e.all  = all;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        inv_t e;
        if (rst) begin
            inv_seen = 0;
        end else begin
            chk("invce_during_refill", bus.invce & bus.refill_wr, 1'b0);
            chk("qualifier_without_invce", (bus.invline | bus.invall) & ~bus.invce, 1'b0);
            if (bus.core_ack) ack_cnt++;
            if (bus.invce) begin
                inv_seen++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_invce", 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    chk("inv_adr", bus.adr, e.a);
                    chk("inv_line", bus.invline, e.line);
                    chk("inv_all", bus.invall, e.all);
                end
            end
        end
    end

    task automatic do_core(input logic [1:0] op, input logic [31:0] a,
                           input logic [7:0] c, output int lat);
        @(posedge clk);
        #1;
        bus.core_req = 1'b1;
        bus.core_op  = op;
        bus.core_adr = a;
        bus.core_cnt = c;
        lat = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.core_ack) begin
                lat = i;
                break;
            end
        end
        if (lat < 0) chk("core_ack_timeout", 1'b0, 1'b1);
        @(posedge clk);
        #1;
        bus.core_req = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!bus.busy && exp_q.size() == 0) break;
        end
        chk({tag, "_busy"}, bus.busy, 1'b0);
        chk({tag, "_stall"}, bus.stall_fetch, 1'b0);
        chk({tag, "_queue_left"}, exp_q.size(), 0);
    endtask

    task automatic chk_stats(input string tag);
`ifdef ICINV_STATS_EN
        chk(tag, bus.inv_count, inv_seen);
`else
        chk(tag, bus.inv_count, 0);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        int a0;
        int s0;

        bus.refill_wr = 1'b0;
        bus.core_req  = 1'b0;
        bus.core_op   = 2'd0;
        bus.core_adr  = '0;
        bus.core_cnt  = '0;
        bus.snp_v     = 1'b0;
        bus.snp_adr   = '0;

        repeat (3) @(posedge clk);
        #2;
        chk("rst_invce", bus.invce, 1'b0);
        chk("rst_invline", bus.invline, 1'b0);
        chk("rst_invall", bus.invall, 1'b0);
        chk("rst_adr", bus.adr, 32'h0);
        chk("rst_core_ack", bus.core_ack, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_stall", bus.stall_fetch, 1'b0);
        chk("rst_snp_rdy", bus.snp_rdy, 1'b1);
        chk("rst_inv_count", bus.inv_count, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // single line, unblocked
        a0 = ack_cnt;
        push_exp(32'h0000_1200, 1'b1, 1'b0);
        do_core(2'd0, 32'h0000_1234, 8'd0, lat);
        chk("line_latency", lat, 3);
        wait_idle("line");
        chk("line_ack_count", ack_cnt - a0, 1);

        // single line held off by refill writes for three issue cycles
        a0 = ack_cnt;
        push_exp(32'h0000_1200, 1'b1, 1'b0);
        fork
            do_core(2'd0, 32'h0000_1234, 8'd0, lat);
            begin
                @(posedge clk);
                #1;
                bus.refill_wr = 1'b1;
                repeat (5) @(posedge clk);
                #1;
                bus.refill_wr = 1'b0;
            end
        join
        chk("blocked_line_latency", lat, 6);
        wait_idle("blocked_line");
        chk("blocked_line_ack_count", ack_cnt - a0, 1);

        // ranges: normal, oversize, exact LINES, zero, wrap; plus all and reserved
        push_exp(32'h0000_1000, 1'b1, 1'b0);
        push_exp(32'h0000_1040, 1'b1, 1'b0);
        push_exp(32'h0000_1080, 1'b1, 1'b0);
        do_core(2'd2, 32'h0000_1000, 8'd3, lat);
        chk("range3_latency", lat, 5);
        wait_idle("range3");

        push_exp(32'h0, 1'b0, 1'b1);
        do_core(2'd2, 32'h0000_1000, 8'd200, lat);
        chk("range200_latency", lat, 3);
        wait_idle("range200");

        push_exp(32'h0, 1'b0, 1'b1);
        do_core(2'd2, 32'h0000_1000, 8'd128, lat);
        chk("range128_latency", lat, 3);
        wait_idle("range128");

        s0 = inv_seen;
        do_core(2'd2, 32'h0000_1000, 8'd0, lat);
        chk("range0_latency", lat, 2);
        wait_idle("range0");
        chk("range0_no_invce", inv_seen - s0, 0);

        push_exp(32'hFFFF_FFC0, 1'b1, 1'b0);
        push_exp(32'h0000_0000, 1'b1, 1'b0);
        do_core(2'd2, 32'hFFFF_FFC5, 8'd2, lat);
        chk("range_wrap_latency", lat, 4);
        wait_idle("range_wrap");

        push_exp(32'h0, 1'b0, 1'b1);
        do_core(2'd1, 32'h0000_5555, 8'd0, lat);
        chk("all_latency", lat, 3);
        wait_idle("all");

        s0 = inv_seen;
        do_core(2'd3, 32'h0000_1000, 8'd5, lat);
        chk("reserved_latency", lat, 2);
        wait_idle("reserved");
        chk("reserved_no_invce", inv_seen - s0, 0);
        chk_stats("stats_after_core_ops");

        // contention, rr=0: snoop wins
        push_exp(32'h0000_2000, 1'b1, 1'b0);
        push_exp(32'h0000_2400, 1'b1, 1'b0);
        fork
            begin
                @(posedge clk);
                #1;
                bus.snp_v   = 1'b1;
                bus.snp_adr = 32'h0000_2017;
                @(posedge clk);
                #1;
                bus.snp_v   = 1'b0;
            end
            begin
                @(posedge clk);
                #1;
                do_core(2'd0, 32'h0000_2400, 8'd0, lat);
            end
        join
        wait_idle("contend1");

        // contention again, rr=1: core wins
        push_exp(32'h0000_3000, 1'b1, 1'b0);
        push_exp(32'h0000_4000, 1'b1, 1'b0);
        fork
            begin
                @(posedge clk);
                #1;
                bus.snp_v   = 1'b1;
                bus.snp_adr = 32'h0000_4000;
                @(posedge clk);
                #1;
                bus.snp_v   = 1'b0;
            end
            begin
                @(posedge clk);
                #1;
                do_core(2'd0, 32'h0000_3000, 8'd0, lat);
            end
        join
        wait_idle("contend2");

        // overflow: FSM stuck on a blocked line op while five snoops arrive
        push_exp(32'h0000_5000, 1'b1, 1'b0);
        push_exp(32'h0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        bus.refill_wr = 1'b1;
        fork
            do_core(2'd0, 32'h0000_5000, 8'd0, lat);
            begin
                @(posedge clk);
                #1;
                for (int i = 0; i < 5; i++) begin
                    @(posedge clk);
                    #1;
                    chk($sformatf("snp_rdy_before_push%0d", i), bus.snp_rdy, (i < 4) ? 1'b1 : 1'b0);
                    bus.snp_v   = 1'b1;
                    bus.snp_adr = 32'h0000_6000 + 32'(i * 64);
                end
                @(posedge clk);
                #1;
                bus.snp_v = 1'b0;
                chk("ovf_snp_rdy_full", bus.snp_rdy, 1'b0);
                chk("ovf_busy", bus.busy, 1'b1);
                chk("ovf_stall", bus.stall_fetch, 1'b1);
                repeat (2) @(posedge clk);
                #1;
                bus.refill_wr = 1'b0;
            end
        join
        wait_idle("overflow");
        chk("overflow_snp_rdy", bus.snp_rdy, 1'b1);
        chk_stats("stats_after_overflow");

        // reset in the middle of a long range
        a0 = ack_cnt;
        for (int i = 0; i < 50; i++) push_exp(32'h0000_8000 + 32'(i * 64), 1'b1, 1'b0);
        @(posedge clk);
        #1;
        bus.core_req = 1'b1;
        bus.core_op  = 2'd2;
        bus.core_adr = 32'h0000_8000;
        bus.core_cnt = 8'd50;
        repeat (4) @(posedge clk);
        @(negedge clk);
        #2;
        chk("mid_range_invce", bus.invce, 1'b1);
        rst = 1'b1;
        #1;
        chk("rstmid_invce", bus.invce, 1'b0);
        chk("rstmid_invline", bus.invline, 1'b0);
        chk("rstmid_adr", bus.adr, 32'h0);
        chk("rstmid_core_ack", bus.core_ack, 1'b0);
        chk("rstmid_busy", bus.busy, 1'b0);
        chk("rstmid_snp_rdy", bus.snp_rdy, 1'b1);
        chk("rstmid_inv_count", bus.inv_count, 32'h0);
        bus.core_req = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("rstmid_no_ack", ack_cnt - a0, 0);
        chk("rstmid_idle", bus.busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/thor2022_icinv_ctrl.md
Name: thor2022_icinv_ctrl

Overview:
- Sequences and arbitrates all invalidate traffic into the instruction-cache valid-bit array.
- Two requesters share the array's single invalidate port: core cache-control ops (line, all, range) and bus write-snoop invalidates (queued in a small FIFO).
- Never drives an invalidate in a cycle where the refill path writes a valid bit; the array gives the write priority and would drop the invalidate.
- Raises a fetch stall while any invalidate is outstanding.

Parameters:
- AWID, 32, physical address width.
- LINES, 128, lines per way (index = adr[12:6], 64-byte lines).
- SNP_DEPTH, 4, snoop FIFO entries (power of 2, min 2).
- CNTW, 8, width of the range line count.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- refill_wr  in  1  refill writes a valid bit this cycle; blocks invce.
- core_req  in  1  core op request; held until core_ack.
- core_op  in  2  00 line, 01 all, 10 range, 11 reserved (acked, no action).
- core_adr  in  AWID  line/start physical address.
- core_cnt  in  CNTW  line count for range.
- core_ack  out  1  one-cycle pulse when the core op completes.
- snp_v  in  1  snoop invalidate address valid.
- snp_adr  in  AWID  snooped write address.
- snp_rdy  out  1  FIFO not full.
- invce  out  1  invalidate enable to the valid array.
- invline  out  1  single-line invalidate.
- invall  out  1  invalidate all ways, all lines.
- adr  out  AWID  invalidate address (line-aligned, bits [5:0]=0).
- busy  out  1  FSM not IDLE or FIFO non-empty.
- stall_fetch  out  1  equals busy.
- inv_count  out  32  invalidate statistics, see Optional Feature.

Behaviour:
- Reset (async): FSM=IDLE; FIFO empty; ovf=0; rr=0. All outputs 0 except snp_rdy=1. Reset mid-operation abandons the op without core_ack.
- Issue gating (combinational): invce = pend & ~refill_wr. invline/invall are qualified by invce, so both are 0 whenever invce=0. An op is consumed only in a cycle with invce=1.
- FSM states: IDLE, ISSUE, RANGE, ACK.
- IDLE arbitration: candidates are FIFO non-empty (snoop) and core_req.
  - If both are pending, rr selects: rr=0 snoop, rr=1 core. rr toggles after each grant while both are pending.
  - Grant is taken in IDLE and registered. adr loads next cycle.
- Snoop grant: pop FIFO; adr={snp_adr[AWID-1:6],6'b0}; invline; go to ISSUE. No ack.
- Core line: as snoop but with core_adr; go to ISSUE, then ACK.
- Core all: invall; go to ISSUE, then ACK.
- Core range:
  - cnt=0 → ACK directly, no invce.
  - cnt>=LINES → treated as all.
  - Otherwise load adr, set remaining=cnt, go to RANGE.
- ISSUE: hold pend=1 until invce=1. Next state is ACK (core op) or IDLE (snoop).
- RANGE: each invce cycle, adr += 64 and remaining -= 1. When remaining reaches 1 and invce=1 → ACK. Address wraps at 2^AWID with no fault.
- ACK: core_ack=1 for exactly one cycle → IDLE. The core must not drop core_req before the ack. core_op/core_adr/core_cnt are sampled only at grant.
- Snoop FIFO:
  - Push on snp_v & snp_rdy; push and pop in the same cycle is allowed at any occupancy.
  - snp_rdy = ~full.
  - snp_v while full: entry dropped, ovf set sticky.
- Overflow recovery: the next snoop grant with ovf=1 issues invall instead of invline, flushes the FIFO, and clears ovf.
- Latency: grant→invce in 1 cycle when refill_wr=0; line op core_req→core_ack in 3 cycles minimum.
- Reserved op: IDLE→ACK, no invce.

Optional Feature:
- ICINV_STATS_EN defined: inv_count increments by 1 on every cycle with invce=1. It saturates at 2^32-1 and resets to 0.
- ICINV_STATS_EN undefined: inv_count tied to 0, no counter logic.

Test Plan:
- Core line, core_adr=0x0000_1234, refill_wr=0 → adr=0x0000_1200, invce=invline=1 for 1 cycle; core_ack 3 cycles after core_req.
- Same line op with refill_wr=1 for 3 cycles → invce held 0 for those 3 cycles, issues on the 4th; single core_ack afterwards.
- Range core_adr=0x1000, core_cnt=3 → invline at adr 0x1000, 0x1040, 0x1080 on consecutive cycles, then core_ack. core_cnt=200 → one invall. core_cnt=0 → core_ack, no invce.
- Core line and snoop (0x2000) pending together with rr=0 → snoop issued first (adr 0x2000), then core; rr alternates on repeated contention.
- 5 snoops back-to-back while blocked by refill_wr=1, SNP_DEPTH=4 → snp_rdy=0 after 4, 5th sets ovf; after release one invall issued, FIFO empty, busy=0.
- Assert rst mid-RANGE → all outputs 0 and snp_rdy=1 immediately; no core_ack; with ICINV_STATS_EN, inv_count=0.
